fetch_issue: RTL and testbench
==============================

Name: fetch_issue

Overview:
- Front end that produces the 4-bit opcode stream consumed by the control decoder.
- Holds the PC and drives the instruction-memory address.
- Latches the instruction and its PC into the IF/ID register, with stall and redirect (jump/branch/jumpMem) handling.
- On a redirect it squashes wrong-path fetch by issuing NOP (opcode 4'b0000) bubbles.

Parameters:
- PC_W, 8: PC and instruction-memory address width.
- INSTR_W, 32: instruction width.
- FLUSH_DEPTH, 2: NOP cycles issued per redirect, including the redirect edge itself; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  PC_W  instruction address; equals pc.
- imem_rdata  in  INSTR_W  instruction at imem_addr, combinational (valid same cycle).
- stall  in  1  hold pc, IF/ID and state.
- redirect  in  1  taken jump/branch/jumpMem from EX.
- redirect_pc  in  PC_W  target PC.
- id_instr  out  INSTR_W  registered instruction.
- id_opcode  out  4  id_instr[31:28], to the control decoder.
- id_rd / id_rs / id_rt  out  6 each  id_instr[27:22] / [21:16] / [15:10].
- id_pc  out  PC_W  PC of id_instr, used by save-pc (1111).
- id_valid  out  1  id_instr is a real, non-squashed instruction.
- illegal_op  out  1  sticky illegal-opcode flag; tied 0 without the macro.

Behaviour:
- Reset (rst_n=0 at an edge): pc=0, id_instr=0, id_pc=0, id_valid=0, illegal_op=0, state=BOOT, flush_cnt=0. Reset wins over every other input.
- Per-edge priority: reset > redirect > stall > normal.
- BOOT, first edge after reset release:
  - pc stays 0; IF/ID unchanged (NOP, invalid); state goes to RUN.
  - redirect in BOOT is handled as in RUN.
- RUN, normal edge:
  - id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
  - pc <= pc+1, modulo 2^PC_W (wraps from 2^PC_W-1 to 0).
- Redirect, any state:
  - pc <= redirect_pc; id_instr <= 0 (NOP); id_valid <= 0; id_pc <= pc.
  - If FLUSH_DEPTH==1: state goes to RUN. Otherwise state goes to FLUSH with flush_cnt = FLUSH_DEPTH-1.
  - Redirect overrides a simultaneous stall.
  - Redirect during FLUSH reloads the counter.
- FLUSH, edge without stall or redirect:
  - pc held; NOP and id_valid=0 issued; flush_cnt decrements.
  - When flush_cnt reaches 1 on this edge, state goes to RUN.
- Stall without redirect: pc, IF/ID, state and flush_cnt all hold.
- Latency:
  - Instruction at address A is visible on id_* one edge after imem_addr==A with stall=0.
  - After a redirect at edge E, the target instruction appears at edge E+FLUSH_DEPTH.
- imem_addr, id_opcode and the id_rd/rs/rt fields are pure functions of registers; there is no combinational path from imem_rdata, stall or redirect.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - A latched opcode outside {0000,0011,0100,0101,0110,0111,1000,1001,1010,1011,1110,1111} is replaced by NOP with id_valid=0.
  - illegal_op is set and stays 1 until reset.
  - pc advances normally.
- Undefined: opcodes pass through unchanged; illegal_op is constant 0.

Decomposition:
- Shared package holds:
  - opcode localparams (NOP, STORE, ADD, INC, NEG, SUB, JUMP, BRZ, JUMPMEM, BRN, LOAD, SAVEPC), shared with the control decoder;
  - field bit positions;
  - NOP_INSTR constant;
  - fetch state encoding (BOOT=0, RUN=1, FLUSH=2);
  - legal-opcode function.
- No sub-module is warranted. PC register, IF/ID register and flush counter stay in one module.

Test Plan:
- Boot: release rst_n with imem[0]=0x4..., imem[1]=0x7... → edge 1 id_valid=0, pc=0; edge 2 id_opcode=0100, id_pc=0; edge 3 id_opcode=0111, id_pc=1.
- Redirect: in RUN at pc=5, pulse redirect with redirect_pc=0x20 and FLUSH_DEPTH=2 → two NOP/invalid cycles, pc=0x20 held; then id_pc=0x20 valid.
- Stall vs redirect:
  - stall=1 for 3 cycles → id_* and pc unchanged.
  - stall=1 and redirect=1 together → redirect taken, pc=redirect_pc.
- Wrap: run pc to 0xFF (PC_W=8) → next imem_addr=0x00; id_pc=0xFF on the preceding issue.
- Reset mid-FLUSH: rst_n=0 while flush_cnt=1 → all outputs at reset values, state BOOT.
- Macro on: opcode 1100 at pc=3 → id_valid=0, illegal_op=1 and stays 1; pc continues to 4.

Source files
------------

// File: rtl/fetch_issue_pkg.sv
// rtl/fetch_issue_pkg.sv - shared opcodes, field positions, fetch states and legal-opcode check
package fetch_issue_pkg;

  // Opcode values, shared with the control decoder
  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0011;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_INC     = 4'b0101;
  localparam logic [3:0] OP_NEG     = 4'b0110;
  localparam logic [3:0] OP_SUB     = 4'b0111;
  localparam logic [3:0] OP_JUMP    = 4'b1000;
  localparam logic [3:0] OP_BRZ     = 4'b1001;
  localparam logic [3:0] OP_JUMPMEM = 4'b1010;
  localparam logic [3:0] OP_BRN     = 4'b1011;
  localparam logic [3:0] OP_LOAD    = 4'b1110;
  localparam logic [3:0] OP_SAVEPC  = 4'b1111;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch state encoding
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // True when the opcode belongs to the implemented instruction set
  function automatic logic legal_opcode(input logic [3:0] op);
    case (op)
      OP_NOP, OP_STORE, OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_JUMP,
      OP_BRZ, OP_JUMPMEM, OP_BRN, OP_LOAD, OP_SAVEPC: legal_opcode = 1'b1;
      default:                                        legal_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_issue.sv
// rtl/fetch_issue.sv - PC, IF/ID register and redirect flush; optional trap via FETCH_ILLEGAL_TRAP_EN
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [3:0]         id_opcode,
  output logic [5:0]         id_rd,
  output logic [5:0]         id_rs,
  output logic [5:0]         id_rt,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
  output logic               illegal_op
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_id_instr;
  logic [PC_W-1:0]    r_id_pc;
  logic               r_id_valid;
  logic [1:0]         r_state;
  logic [3:0]         r_flush_cnt;
  logic               w_latch_ok;

  // Counter reload value after a redirect edge (that edge itself is the first bubble)
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_DEPTH - 1);

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign w_latch_ok = legal_opcode(imem_rdata[OPC_MSB:OPC_LSB]);
  assign illegal_op = r_illegal;

  // Sticky illegal flag: set on any RUN latch of an unimplemented opcode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (!redirect && !stall && r_state == ST_RUN && !w_latch_ok) begin
      r_illegal <= 1'b1;
    end
  end
`else
  assign w_latch_ok = 1'b1;
  assign illegal_op = 1'b0;
`endif

  // PC, IF/ID and fetch state: reset > redirect > stall > normal
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_id_instr  <= '0;
      r_id_pc     <= '0;
      r_id_valid  <= 1'b0;
      r_state     <= ST_BOOT;
      r_flush_cnt <= 4'd0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_id_instr <= INSTR_W'(NOP_INSTR);
      r_id_valid <= 1'b0;
      r_id_pc    <= r_pc;
      if (FLUSH_DEPTH == 1) begin
        r_state <= ST_RUN;
      end else begin
        r_state     <= ST_FLUSH;
        r_flush_cnt <= FLUSH_RELOAD;
      end
    end else if (!stall) begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // An illegal opcode still consumes its slot so the PC keeps moving
          r_id_instr <= w_latch_ok ? imem_rdata : INSTR_W'(NOP_INSTR);
          r_id_valid <= w_latch_ok;
          r_id_pc    <= r_pc;
          r_pc       <= r_pc + 1'b1;
        end
        ST_FLUSH: begin
          r_id_instr  <= INSTR_W'(NOP_INSTR);
          r_id_valid  <= 1'b0;
          r_flush_cnt <= r_flush_cnt - 4'd1;
          if (r_flush_cnt <= 4'd1) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign id_instr  = r_id_instr;
  assign id_opcode = r_id_instr[OPC_MSB:OPC_LSB];
  assign id_rd     = r_id_instr[RD_MSB:RD_LSB];
  assign id_rs     = r_id_instr[RS_MSB:RS_LSB];
  assign id_rt     = r_id_instr[RT_MSB:RT_LSB];
  assign id_pc     = r_id_pc;
  assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_fetch_issue.sv
// tb/tb_fetch_issue.sv - directed self-checking bench for fetch_issue
module tb_fetch_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [31:0] id_instr;
  logic [3:0]  id_opcode;
  logic [5:0]  id_rd, id_rs, id_rt;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        illegal_op;

  logic [31:0] imem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];

  fetch_issue #(.PC_W(8), .INSTR_W(32), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs(id_rs),
    .id_rt(id_rt), .id_pc(id_pc), .id_valid(id_valid), .illegal_op(illegal_op)
  );

  // Advance one edge and sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    step(); step();
    n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", imem_addr); end
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_tests++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
    n_tests++; if (id_pc !== 8'h00) begin n_fail++; $display("FAIL reset_id_pc: got %h expected 00", id_pc); end
    n_tests++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    step();
    n_tests++; if (id_valid !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL boot_edge1: got valid=%b addr=%h expected valid=0 addr=00", id_valid, imem_addr); end
    step();
    n_tests++; if (id_opcode !== 4'b0100 || id_pc !== 8'h00 || id_valid !== 1'b1) begin n_fail++; $display("FAIL boot_edge2: got op=%h pc=%h valid=%b expected op=4 pc=00 valid=1", id_opcode, id_pc, id_valid); end
    step();
    n_tests++; if (id_opcode !== 4'b0111 || id_pc !== 8'h01 || imem_addr !== 8'h02) begin n_fail++; $display("FAIL boot_edge3: got op=%h pc=%h addr=%h expected op=7 pc=01 addr=02", id_opcode, id_pc, imem_addr); end
    n_tests++; if (id_rd !== 6'h2A || id_rs !== 6'h15 || id_rt !== 6'h33) begin n_fail++; $display("FAIL boot_fields: got rd=%h rs=%h rt=%h expected 2a 15 33", id_rd, id_rs, id_rt); end
    step(); step(); step();
    n_tests++; if (imem_addr !== 8'h05 || id_pc !== 8'h04) begin n_fail++; $display("FAIL run_addr5: got addr=%h id_pc=%h expected 05 04", imem_addr, id_pc); end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 8'h20;
    step();
    redirect = 1'b0;
    n_tests++; if (id_valid !== 1'b0 || id_opcode !== 4'h0 || imem_addr !== 8'h20 || id_pc !== 8'h05) begin n_fail++; $display("FAIL redir_e0: got valid=%b op=%h addr=%h id_pc=%h expected 0 0 20 05", id_valid, id_opcode, imem_addr, id_pc); end
    step();
    n_tests++; if (id_valid !== 1'b0 || id_opcode !== 4'h0 || imem_addr !== 8'h20) begin n_fail++; $display("FAIL redir_e1: got valid=%b op=%h addr=%h expected 0 0 20", id_valid, id_opcode, imem_addr); end
    step();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 8'h20 || id_instr !== 32'h5ABC_DE20 || imem_addr !== 8'h21) begin n_fail++; $display("FAIL redir_e2: got valid=%b id_pc=%h instr=%h addr=%h expected 1 20 5abcde20 21", id_valid, id_pc, id_instr, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (imem_addr !== 8'h21 || id_pc !== 8'h20 || id_valid !== 1'b1 || id_instr !== 32'h5ABC_DE20) begin n_fail++; $display("FAIL stall_hold%0d: got addr=%h id_pc=%h valid=%b instr=%h expected 21 20 1 5abcde20", i, imem_addr, id_pc, id_valid, id_instr); end
    end
    redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0; stall = 1'b0;
    n_tests++; if (imem_addr !== 8'h40 || id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_redirect: got addr=%h valid=%b expected 40 0", imem_addr, id_valid); end
    step(); step();
    n_tests++; if (id_pc !== 8'h40 || id_valid !== 1'b1 || imem_addr !== 8'h41) begin n_fail++; $display("FAIL stall_redirect_target: got id_pc=%h valid=%b addr=%h expected 40 1 41", id_pc, id_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    step(); step();
    n_tests++; if (id_pc !== 8'hFE || imem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_fe: got id_pc=%h addr=%h expected fe ff", id_pc, imem_addr); end
    step();
    n_tests++; if (id_pc !== 8'hFF || imem_addr !== 8'h00 || id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ff: got id_pc=%h addr=%h valid=%b expected ff 00 1", id_pc, imem_addr, id_valid); end
  endtask

  task automatic test_reset_flush();
    redirect = 1'b1; redirect_pc = 8'h10;
    step();
    redirect = 1'b0; rst_n = 1'b0;
    step();
    n_tests++; if (imem_addr !== 8'h00 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 8'h00) begin n_fail++; $display("FAIL rst_flush: got addr=%h valid=%b instr=%h id_pc=%h expected 00 0 0 00", imem_addr, id_valid, id_instr, id_pc); end
    rst_n = 1'b1;
    step();
    n_tests++; if (imem_addr !== 8'h00 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush_boot: got addr=%h valid=%b expected 00 0", imem_addr, id_valid); end
    step();
    n_tests++; if (id_pc !== 8'h00 || id_valid !== 1'b1 || id_opcode !== 4'h4) begin n_fail++; $display("FAIL rst_flush_run: got id_pc=%h valid=%b op=%h expected 00 1 4", id_pc, id_valid, id_opcode); end
  endtask

  task automatic test_illegal();
    // After the previous task: pc=1, RUN. Two edges latch imem[1], imem[2]; the third latches imem[3]
    step(); step(); step();
    n_tests++; if (id_pc !== 8'h03 || imem_addr !== 8'h04) begin n_fail++; $display("FAIL illegal_pc: got id_pc=%h addr=%h expected 03 04", id_pc, imem_addr); end
`ifdef FETCH_ILLEGAL_TRAP_EN
    n_tests++; if (id_valid !== 1'b0 || id_opcode !== 4'h0 || illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_trap: got valid=%b op=%h ill=%b expected 0 0 1", id_valid, id_opcode, illegal_op); end
    step();
    n_tests++; if (illegal_op !== 1'b1 || id_valid !== 1'b1 || imem_addr !== 8'h05) begin n_fail++; $display("FAIL illegal_sticky: got ill=%b valid=%b addr=%h expected 1 1 05", illegal_op, id_valid, imem_addr); end
`else
    n_tests++; if (id_valid !== 1'b1 || id_opcode !== 4'hC || illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_pass: got valid=%b op=%h ill=%b expected 1 c 0", id_valid, id_opcode, illegal_op); end
    step();
    n_tests++; if (illegal_op !== 1'b0 || imem_addr !== 8'h05) begin n_fail++; $display("FAIL illegal_quiet: got ill=%b addr=%h expected 0 05", illegal_op, imem_addr); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = {12'h5AB, 12'hCDE, i[7:0]};
    imem[0] = 32'h4000_0000;
    imem[1] = {4'h7, 6'h2A, 6'h15, 6'h33, 10'h000};
    imem[3] = 32'hC000_0003;
    test_reset();
    test_boot();
    test_redirect();
    test_stall();
    test_wrap();
    test_reset_flush();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
